// File: rtl/mem_access_arbiter.sv
// Two-requester round-robin arbiter in front of a small flip-flop memory.
// Each access runs IDLE -> ACCESS -> RESP, so one access completes every 3 cycles.
module mem_access_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              Clk,
  input  logic              R,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addy0,
  input  logic [ADDR_W-1:0] addy1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                id_q, id_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_we;
  logic                winner;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    winner  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that was not served last time wins.
          winner  = (req0 && req1) ? ~last_q : req1;
          id_d    = winner;
          last_d  = winner;
          we_d    = winner ? we1 : we0;
          addr_d  = winner ? addy1 : addy0;
          wdata_d = winner ? wdata1 : wdata0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_we  = we_q;
        rdata_d = we_q ? wdata_q : mem_q[addr_q];
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge R) begin
    if (R) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge Clk or posedge R) begin
    if (R) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign gnt0  = (state_q == ACCESS) && !id_q;
  assign gnt1  = (state_q == ACCESS) &&  id_q;
  assign done0 = (state_q == RESP)   && !id_q;
  assign done1 = (state_q == RESP)   &&  id_q;
  assign busy  = (state_q != IDLE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grants, completions and read
// data; a negedge monitor compares every cycle and pops responses on done pulses.
module tb_mem_access_arbiter;

  logic       Clk = 1'b0;
  logic       R = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [3:0] addy0 = '0, addy1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [7:0] rdata;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  mem_access_arbiter #(.DATA_W(8), .ADDR_W(4)) dut (
    .Clk(Clk), .R(R),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addy0(addy0), .addy1(addy1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .busy(busy)
  );

  typedef struct {
    logic       id;
    logic [7:0] data;
  } resp_t;

  // Reference model: a word array, a round-robin pointer and a cycles-remaining count.
  logic [7:0] m_mem [16] = '{default: 8'h00};
  logic       m_last = 1'b1;
  logic       m_id = 1'b0;
  logic       m_we = 1'b0;
  logic [3:0] m_addr = '0;
  logic [7:0] m_wd = '0;
  logic [7:0] m_rdata = '0;
  int         m_left = 0;
  logic       gnt_q[$];
  resp_t      resp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk or posedge R) begin
    if (R) begin
      m_last  = 1'b1;
      m_left  = 0;
      m_rdata = 8'h00;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      gnt_q.delete();
      resp_q.delete();
    end else if (m_left == 0) begin
      if (req0 || req1) begin
        if (req0 && req1) m_id = !m_last;
        else              m_id = req1;
        m_last = m_id;
        m_we   = m_id ? we1 : we0;
        m_addr = m_id ? addy1 : addy0;
        m_wd   = m_id ? wdata1 : wdata0;
        m_left = 2;
        gnt_q.push_back(m_id);
      end
    end else if (m_left == 2) begin
      if (m_we) begin
        m_mem[m_addr] = m_wd;
        m_rdata = m_wd;
      end else begin
        m_rdata = m_mem[m_addr];
      end
      resp_q.push_back('{id: m_id, data: m_rdata});
      m_left = 1;
    end else begin
      m_left = 0;
    end
  end

  // Monitor
  always @(negedge Clk) begin
    resp_t r;
    logic  g;
    if (R) begin
      check("reset_gnt",   {gnt1, gnt0}, 32'h0);
      check("reset_done",  {done1, done0}, 32'h0);
      check("reset_busy",  busy, 32'h0);
      check("reset_rdata", rdata, 32'h0);
    end else begin
      check("busy",  busy, (m_left != 0));
      check("gnt0",  gnt0, (m_left == 2) && !m_id);
      check("gnt1",  gnt1, (m_left == 2) &&  m_id);
      check("done0", done0, (m_left == 1) && !m_id);
      check("done1", done1, (m_left == 1) &&  m_id);
      check("rdata_hold", rdata, m_rdata);
      if (gnt0 || gnt1) begin
        if (gnt_q.size() == 0) begin
          check("gnt_unexpected", {gnt1, gnt0}, 32'h0);
        end else begin
          g = gnt_q.pop_front();
          check("gnt_id", gnt1, g);
        end
      end
      if (done0 || done1) begin
        if (resp_q.size() == 0) begin
          check("done_unexpected", {done1, done0}, 32'h0);
        end else begin
          r = resp_q.pop_front();
          check("done_id", done1, r.id);
          check("done_rdata", rdata, r.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic we, input logic [3:0] a, input logic [7:0] d);
    if (id) begin req1 = 1'b1; we1 = we; addy1 = a; wdata1 = d; end
    else    begin req0 = 1'b1; we0 = we; addy0 = a; wdata0 = d; end
  endtask

  task automatic single(input logic id, input logic we, input logic [3:0] a, input logic [7:0] d);
    drive(id, we, a, d);
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    repeat (3) tick();
    R = 1'b0;
    tick();

    // Write then read back the same word.
    single(1'b0, 1'b1, 4'd3, 8'hA5);
    single(1'b0, 1'b0, 4'd3, 8'h00);

    // Tie after reset: both held, grants alternate starting with 0.
    R = 1'b1; tick(); R = 1'b0; tick();
    drive(1'b0, 1'b0, 4'd3, 8'h11);
    drive(1'b1, 1'b0, 4'd5, 8'h22);
    repeat (12) tick();
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) tick();

    // Captured write data must not follow later input changes.
    drive(1'b1, 1'b1, 4'd7, 8'h3C);
    tick();
    req1 = 1'b0;
    wdata1 = 8'hFF;
    repeat (3) tick();
    single(1'b1, 1'b0, 4'd7, 8'h00);

    // Reset during ACCESS aborts the write.
    drive(1'b0, 1'b1, 4'd2, 8'h55);
    tick();
    req0 = 1'b0;
    R = 1'b1;
    tick();
    R = 1'b0;
    tick();
    single(1'b0, 1'b0, 4'd2, 8'h00);

    // Request pulse that is gone before the sampling edge.
    req0 = 1'b1;
    #2;
    req0 = 1'b0;
    repeat (3) tick();

    // Boundary addresses.
    single(1'b0, 1'b1, 4'd0,  8'h01);
    single(1'b1, 1'b1, 4'd15, 8'h80);
    single(1'b1, 1'b0, 4'd0,  8'h00);
    single(1'b0, 1'b0, 4'd15, 8'h00);

    // Random traffic, including requests that arrive while busy.
    for (int n = 0; n < 400; n++) begin
      req0   = ($urandom_range(0, 2) == 0);
      req1   = ($urandom_range(0, 2) == 0);
      we0    = $urandom_range(0, 1);
      we1    = $urandom_range(0, 1);
      addy0  = 4'($urandom_range(0, 3));
      addy1  = 4'($urandom_range(0, 3));
      wdata0 = 8'($urandom);
      wdata1 = 8'($urandom);
      if ($urandom_range(0, 99) == 0) R = 1'b1;
      tick();
      R = 1'b0;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (5) tick();

    check("pending_grants", gnt_q.size(), 32'h0);
    check("pending_responses", resp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
